// File: rtl/aes_blk_fetch.sv
// Block fetcher feeding the AES inverse cipher: reads WPB RAM words per block, packs MSB-first,
// strobes ld and waits for done. Optional core watchdog selected by the AES_FETCH_TMO_EN macro.
module aes_blk_fetch #(
  parameter int RAM_AW  = 8,
  parameter int RAM_DW  = 8,
  parameter int BLK_W   = 128,
  parameter int NB_W    = 5,
  parameter int TMO_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAM_AW-1:0] base_addr,
  input  logic [NB_W-1:0]   nblk,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [RAM_DW-1:0] ram_rdata,
  output logic              ld,
  output logic [BLK_W-1:0]  blk_data,
  input  logic              done,
  output logic              busy,
  output logic [NB_W-1:0]   blk_idx,
  output logic              frame_done,
  output logic              err,
  output logic [2:0]        fsm_state
);

  localparam int WPB = BLK_W / RAM_DW;
  localparam int CW  = $clog2(WPB + 1);

  // Core handshake: ld is a single-cycle strobe with blk_data valid; the core answers with a
  // done pulse that is only honoured in S_WAIT, so a done coincident with ld is dropped.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   wcnt;
  logic [NB_W-1:0] nblk_q;
  logic            tmo_hit;

  assign fsm_state = state;

`ifdef AES_FETCH_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_WAIT) ? tmo_cnt + TW'(1) : '0;
      if (state == S_IDLE && start)
        err <= 1'b0;
      else if (state == S_WAIT && !done && tmo_hit)
        err <= 1'b1;
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TMO_CYC != 0);
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ram_addr   <= '0;
      ld         <= 1'b0;
      blk_data   <= '0;
      busy       <= 1'b0;
      blk_idx    <= '0;
      frame_done <= 1'b0;
      wcnt       <= '0;
      nblk_q     <= '0;
    end else begin
      ld         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            nblk_q  <= nblk;
            blk_idx <= '0;
            wcnt    <= '0;
            busy    <= 1'b1;
            if (nblk == '0) begin
              state      <= S_FIN;
              frame_done <= 1'b1;
            end else begin
              ram_addr <= base_addr;
              state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // wcnt counts addresses issued; data for address k arrives while wcnt == k+1.
          if (wcnt != '0)
            blk_data <= (blk_data << RAM_DW) | BLK_W'(ram_rdata);
          if (wcnt == CW'(WPB)) begin
            state <= S_LOAD;
            ld    <= 1'b1;
          end else begin
            ram_addr <= ram_addr + RAM_AW'(1);
            wcnt     <= wcnt + CW'(1);
          end
        end
        S_LOAD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            if (blk_idx == nblk_q - NB_W'(1)) begin
              state      <= S_FIN;
              frame_done <= 1'b1;
            end else begin
              blk_idx <= blk_idx + NB_W'(1);
              wcnt    <= '0;
              state   <= S_FETCH;
            end
          end else if (tmo_hit) begin
            state      <= S_FIN;
            frame_done <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
